// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester line encoder/decoder pair:
// FSM state encodings, oversampling legality helpers and the idle line level.
package manchester_pkg;

    // Decoder FSM state encoding (kept as plain constants for legacy tools)
    typedef logic [2:0] state_t;
    localparam state_t ST_GAP      = 3'd0;
    localparam state_t ST_IDLE     = 3'd1;
    localparam state_t ST_WAIT_A   = 3'd2;
    localparam state_t ST_WAIT_MID = 3'd3;
    localparam state_t ST_WAIT_B   = 3'd4;

    // Oversampling must be even so OVS/2 lands exactly mid-half-bit
    localparam int OVS_MIN = 4;

    // Level the line rests at between frames (encoder drives this too)
    localparam logic IDLE_LEVEL = 1'b0;

    // Counter must reach 2*OVS+2 (mid-bit timeout) without wrapping
    function automatic int cnt_width(input int ovs);
        return $clog2(2 * ovs + 3);
    endfunction

    function automatic bit ovs_legal(input int ovs);
        return (ovs >= OVS_MIN) && ((ovs % 2) == 0);
    endfunction

endpackage

// File: rtl/manchester_rx_decoder_line_sync.sv
// Two-flop synchronizer for the asynchronous Manchester line, plus a one-cycle
// delayed copy used to detect any edge and rising edges on the synchronized line.
module manchester_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_s,
    output logic line_edge,
    output logic line_rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Next-state of the synchronizer chain and the delay stage
    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Synchronizer and delay flops, cleared to the reset level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign line_s    = sync_q;
    assign line_edge = sync_q ^ dly_q;
    assign line_rise = sync_q & ~dly_q;

endmodule

// File: rtl/manchester_rx_decoder.sv
// Oversampling Manchester receiver: locks onto each mid-bit transition,
// rebuilds LSB-first words and presents them through a 1-entry valid/ready
// output register with overrun and code-violation pulses.
module manchester_rx_decoder
    import manchester_pkg::*;
#(
    parameter int OVS       = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 line_in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = cnt_width(OVS);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * OVS + 2);
    localparam logic [CW-1:0] B_AT     = CW'(OVS / 2);
    localparam logic [CW-1:0] A_AT     = CW'(OVS + OVS / 2);
    localparam logic [CW-1:0] WIN_LO   = CW'(2 * OVS - 1);
    localparam logic [CW-1:0] WIN_HI   = CW'(2 * OVS + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(2 * OVS - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);

    generate
        if (!ovs_legal(OVS)) begin : g_ovs_illegal
            $error("manchester_rx_decoder: OVS must be even and >= 4");
        end
    endgenerate

    logic line_s, line_edge, line_rise;

    manchester_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (line_in),
        .line_s    (line_s),
        .line_edge (line_edge),
        .line_rise (line_rise)
    );

    state_t                 state_q,    state_d;
    logic [CW-1:0]          cnt_q,      cnt_d;
    logic                   start_q,    start_d;
    logic [IW-1:0]          bit_idx_q,  bit_idx_d;
    logic                   a_q,        a_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   done_q,     done_d;
    logic                   err_q,      err_d;
    logic [DATA_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q,  overrun_d;
    logic [CW-1:0]          cnt_inc;

    // Bit-recovery FSM. cnt_q holds the cycles elapsed since the reference
    // edge: the reference cycle is count 0, so the following cycle reads 1.
    // This keeps the resync window symmetric (+/-1 cycle) around 2*OVS.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        bit_idx_d = bit_idx_q;
        a_d       = a_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        if (!en) begin
            state_d = ST_GAP;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_GAP: begin
                    // cnt_q counts consecutive idle-level samples here
                    if (line_s != IDLE_LEVEL) begin
                        cnt_d = '0;
                    end else if (cnt_q >= GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_IDLE: begin
                    if (line_rise) begin
                        cnt_d   = CW'(1);
                        start_d = 1'b1;
                        state_d = ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == B_AT) begin
                        if (start_q) begin
                            if (line_s) begin
                                start_d   = 1'b0;
                                bit_idx_d = '0;
                                state_d   = ST_WAIT_A;
                            end else begin
                                // false start: quietly rearm
                                cnt_d   = '0;
                                state_d = ST_GAP;
                            end
                        end else if (line_s == a_q) begin
                            err_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_GAP;
                        end else begin
                            shift_d[bit_idx_q] = line_s;
                            if (bit_idx_q == BIT_LAST) begin
                                done_d  = 1'b1;
                                cnt_d   = '0;
                                state_d = ST_GAP;
                            end else begin
                                bit_idx_d = bit_idx_q + IW'(1);
                                state_d   = ST_WAIT_A;
                            end
                        end
                    end
                end
                ST_WAIT_A: begin
                    // bit-boundary edges land here and are ignored
                    cnt_d = cnt_inc;
                    if (cnt_q == A_AT) begin
                        a_d     = line_s;
                        state_d = ST_WAIT_MID;
                    end
                end
                ST_WAIT_MID: begin
                    if (line_edge && (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI)) begin
                        cnt_d   = CW'(1);
                        state_d = ST_WAIT_B;
                    end else if (line_edge || (cnt_q == CNT_MAX)) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            endcase
        end
    end

    // Output register: load a completed word if the slot is free or being
    // drained this cycle, otherwise keep the old word and flag the drop.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done_q) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_GAP;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            bit_idx_q   <= '0;
            a_q         <= 1'b0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            bit_idx_q   <= bit_idx_d;
            a_q         <= a_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_GAP) && (state_q != ST_IDLE);

endmodule

// File: tb/tb_manchester_rx_decoder.sv
// Bench for manchester_rx_decoder: a frame table plus hand-written sequences
// for overrun, glitch, enable abort and mid-frame reset. Expected words go to
// a scoreboard queue and are compared when the DUT completes a handshake.
module tb_manchester_rx_decoder;

    localparam int OVS       = 4;
    localparam int DATA_BITS = 8;
    localparam int NHALF     = 2 * (DATA_BITS + 1);
    localparam int IDLE_GAP  = 32;

    typedef struct {
        logic [7:0] data;
        int         kill_bit;
        int         stretch_h;
        int         shrink_h;
        bit         exp_word;
        bit         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       line_in = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       err;
    logic       overrun;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] exp_w;

    manchester_rx_decoder #(.OVS(OVS), .DATA_BITS(DATA_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .line_in   (line_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: pulse counters and scoreboard compare on each handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (err)     err_cnt++;
            if (overrun) ovr_cnt++;
            if (busy)    busy_seen = 1'b1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %02h expected none", out_data);
                end else begin
                    exp_w = sb.pop_front();
                    check("word", out_data, exp_w);
                end
            end
        end
    end

    task automatic idle(input int n);
        line_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame (start '1' + data LSB first). Optional: drop the mid
    // transition of one data bit, stretch/shrink one half-bit by a cycle,
    // or return early when reaching half-bit index stop_h.
    task automatic send_frame(input logic [7:0] data, input int kill_bit,
                              input int stretch_h, input int shrink_h, input int stop_h);
        for (int h = 0; h < NHALF; h++) begin
            int   k;
            int   len;
            logic b;
            logic lvl;
            k   = h / 2;
            b   = (k == 0) ? 1'b1 : data[k-1];
            lvl = ((h % 2) == 0) ? ~b : b;
            if (kill_bit >= 0 && k == kill_bit + 1 && (h % 2) == 1) lvl = ~b;
            len = OVS + ((h == stretch_h) ? 1 : 0) - ((h == shrink_h) ? 1 : 0);
            if (h == stop_h) return;
            line_in = lvl;
            repeat (len) begin
                @(posedge clk);
                #1;
            end
        end
        line_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [6];
        int   e0;
        int   o0;

        vecs[0] = '{8'hA5, -1, -1, -1, 1'b1, 1'b0};
        vecs[1] = '{8'h55,  3, -1, -1, 1'b0, 1'b1};
        vecs[2] = '{8'h55, -1, -1, -1, 1'b1, 1'b0};
        vecs[3] = '{8'hF0, -1,  6,  7, 1'b1, 1'b0};
        vecs[4] = '{8'h00, -1, -1, -1, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, -1, -1, -1, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_err",       err,       0);
        check("rst_overrun",   overrun,   0);
        check("rst_busy",      busy,      0);
        rst = 1'b0;
        idle(16);

        // Table of frames
        for (int i = 0; i < 6; i++) begin
            e0 = err_cnt;
            o0 = ovr_cnt;
            if (vecs[i].exp_word) sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].kill_bit, vecs[i].stretch_h, vecs[i].shrink_h, -1);
            idle(IDLE_GAP);
            if (vecs[i].exp_err)
                check($sformatf("v%0d_err_seen", i), 32'(err_cnt > e0), 1);
            else
                check($sformatf("v%0d_err_none", i), err_cnt - e0, 0);
            check($sformatf("v%0d_overrun", i), ovr_cnt - o0, 0);
            check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
        end

        // Overrun: two frames into a stalled output register
        out_ready = 1'b0;
        o0 = ovr_cnt;
        sb.push_back(8'h3C);
        send_frame(8'h3C, -1, -1, -1, -1);
        idle(IDLE_GAP);
        send_frame(8'h81, -1, -1, -1, -1);
        idle(IDLE_GAP);
        check("ovr_pulses",     ovr_cnt - o0, 1);
        check("ovr_hold_valid", out_valid, 1);
        check("ovr_hold_data",  out_data, 8'h3C);
        out_ready = 1'b1;
        idle(4);
        check("ovr_drained",     sb.size(), 0);
        check("ovr_valid_clear", out_valid, 0);

        // One-cycle glitch on the idle line: false start, no error
        e0 = err_cnt;
        busy_seen = 1'b0;
        line_in = 1'b1;
        @(posedge clk);
        #1;
        idle(IDLE_GAP);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_err",       err_cnt - e0, 0);
        check("glitch_busy_end",  busy, 0);

        // Enable dropped mid-frame: silent abort
        e0 = err_cnt;
        send_frame(8'h99, -1, -1, -1, 8);
        check("en_busy_before", busy, 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_busy_after", busy, 0);
        idle(8);
        en = 1'b1;
        idle(IDLE_GAP);
        check("en_err", err_cnt - e0, 0);

        // Reset at data bit 4 with a pending word in the output register
        out_ready = 1'b0;
        sb.push_back(8'h5A);
        send_frame(8'h5A, -1, -1, -1, -1);
        idle(IDLE_GAP);
        check("rstmid_pre_valid", out_valid, 1);
        send_frame(8'h33, -1, -1, -1, 10);
        check("rstmid_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_data",  out_data,  0);
        check("rstmid_busy",      busy,      0);
        check("rstmid_err",       err,       0);
        check("rstmid_overrun",   overrun,   0);
        sb.delete();
        line_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle(16);
        sb.push_back(8'h0F);
        send_frame(8'h0F, -1, -1, -1, -1);
        idle(IDLE_GAP);
        check("rstmid_next_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
